pong_pio_irq: RTL and testbench
===============================

// Module: pong_pio_irq
// PURPOSE
//  Parametrised Avalon-MM PIO for the Pong SoC: a WIDTH-bit output register with atomic set/clear
//  and a WIDTH-bit synchronised input with per-bit edge capture and a maskable level IRQ.
//  Replaces single-purpose 8-bit output PIOs (busy flags, paddle buttons, score strobes).
//  Sits on the Nios II data master as a zero-wait-state slave.
// PARAMETERS
//  WIDTH        8   port width, 1..32
//  RESET_VALUE  0   reset value of out_port (WIDTH bits)
//  EDGE_TYPE    0   edges captured: 0 rising, 1 falling, 2 any
//  SYNC_STAGES  2   input synchroniser depth, 2..4
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      Avalon word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data; bits above WIDTH ignored
//  readdata    out  32     read data; bits above WIDTH are 0
//  in_port     in   WIDTH  asynchronous external inputs
//  out_port    out  WIDTH  output register
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Register map (wr = chipselect & ~write_n):
//   0 DATA   R: synchronised in_port           W: out_reg <= wd
//   1 OUTRB  R: out_reg                        W: ignored
//   2 MASK   R/W: irq_mask
//   3 EDGE   R: edge_cap                       W: edge_cap &= ~wd (write-1-to-clear)
//   4 OUTSET R: 0                              W: out_reg <= out_reg | wd
//   5 OUTCLR R: 0                              W: out_reg <= out_reg & ~wd
//   6,7      R: 0                              W: ignored
//  - readdata is combinational from address and registers. Zero wait states; chipselect not needed for reads.
//  - Register writes take effect on the clk edge of the write cycle. out_port = out_reg, visible 1 cycle later.
//  - Reset: out_reg = RESET_VALUE; irq_mask = 0; edge_cap = 0; sync chain and prev = 0; armed = 0; irq = 0.
//  - Synchroniser: SYNC_STAGES flops per bit. sync_in = last stage; prev = sync_in delayed 1 cycle.
//  - Edge detection:
//     rise = sync_in & ~prev;  fall = ~sync_in & prev;  any = rise | fall
//     Selected per EDGE_TYPE. in_port to edge_cap latency is SYNC_STAGES+1 cycles.
//  - Arm counter: edge capture is suppressed for SYNC_STAGES+1 cycles after reset deassertion.
//     This prevents spurious edges from inputs already high at reset. armed stays 1 until next reset.
//  - edge_cap bit is sticky: set on a detected edge (when armed), cleared only by an EDGE write-1 or reset.
//  - Simultaneous edge detection and W1C on the same bit: set wins, bit stays 1.
//  - Simultaneous edges on several bits: all captured in the same cycle.
//  - irq is a registered OR-reduction of (edge_cap & irq_mask), 1 cycle after either changes.
//     No combinational path from in_port or the bus to irq.
//  - Pulse narrower than 1 clk may be missed. No requirement to capture it.
//  - Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); re-arm sequence repeats.
//  - WIDTH=32: bit indexing must not overflow. WIDTH<32: upper readdata bits are hard 0.
// STRUCTURE
//  - Package pong_pio_pkg:
//     address constants PIO_DATA..PIO_OUTCLR
//     EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
//  - Sub-module pong_pio_sync (WIDTH, SYNC_STAGES): per-bit flop chain, async reset to 0.
//  - Top module holds the registers, edge logic, arm counter, read mux and irq flop.
// TESTING (WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2 unless noted)
//  1. Reset with RESET_VALUE=8'hA5:
//     out_port=A5, read OUTRB=0x000000A5, MASK=0, EDGE=0, irq=0.
//  2. Write DATA=0xFFFFFF3C -> out_port=3C, OUTRB reads 0x3C.
//     Then OUTSET 0x81 -> BD; OUTCLR 0x0C -> B1. Reads of addr 4/5/6 return 0.
//  3. Hold in_port=0xFF through reset release -> EDGE stays 0 (arm window).
//     Then in_port 0x00->0x04 -> EDGE=0x04 exactly 3 cycles later; DATA reads 0x04.
//  4. MASK=0x04, edge on bit 2 -> irq=1 one cycle after edge_cap sets.
//     Write EDGE=0x04 -> edge_cap clears, irq falls the following cycle.
//     Write MASK=0 with edge pending -> irq falls.
//  5. W1C of bit 2 in the same cycle its new edge is detected -> bit 2 remains 1.
//     W1C of 0x01 leaves bit 2 untouched.
//  6. EDGE_TYPE=2, WIDTH=32: toggle in_port[31] 0->1->0 -> edge_cap[31] set on each transition.
//     Assert reset_n=0 while irq=1 -> irq and all registers clear within the same cycle.

Source files
------------

// File: rtl/pong_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pio_pkg
//  Purpose  : Shared constants for the Pong SoC parametrised PIO: Avalon word
//             addresses of the register map and the edge-type encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pong_pio_pkg;

    // Avalon word addresses of the register map
    localparam logic [2:0] PIO_DATA   = 3'd0;
    localparam logic [2:0] PIO_OUTRB  = 3'd1;
    localparam logic [2:0] PIO_MASK   = 3'd2;
    localparam logic [2:0] PIO_EDGE   = 3'd3;
    localparam logic [2:0] PIO_OUTSET = 3'd4;
    localparam logic [2:0] PIO_OUTCLR = 3'd5;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pong_pio_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pio_sync
//  Purpose  : Per-bit multi-flop synchroniser for asynchronous PIO inputs.
//  Ports    : clk      in   system clock
//             reset_n  in   asynchronous active-low reset (chain clears to 0)
//             d_in     in   WIDTH asynchronous inputs
//             sync_out out  WIDTH inputs after SYNC_STAGES flops
//  Revision : 1.0 - initial release
// ============================================================================
module pong_pio_sync
    import pong_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] sync_out
);

    // Stage 0 is the first flop behind the pin; the top stage is the output.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pong_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pio_irq
//  Purpose  : Avalon-MM zero-wait-state PIO: WIDTH-bit output register with
//             atomic set/clear, synchronised input with sticky per-bit edge
//             capture and a maskable, registered level interrupt.
//  Ports    : clk, reset_n (async, active-low)
//             address[2:0], chipselect, write_n, writedata[31:0]  Avalon slave
//             readdata[31:0]   combinational read data, upper bits zero
//             in_port[WIDTH]   asynchronous external inputs
//             out_port[WIDTH]  output register
//             irq              level interrupt, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module pong_pio_irq
    import pong_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    // Capture stays blocked until the synchroniser and prev flop have been
    // flushed once, so inputs already high at reset do not look like edges.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;
    logic [31:0]      unused_wd;

    logic [WIDTH-1:0] out_reg_q,  out_reg_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [CNT_W-1:0] arm_cnt_q,  arm_cnt_d;
    logic             armed_q,    armed_d;
    logic             irq_q,      irq_d;

    pong_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (in_port),
        .sync_out (sync_in)
    );

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = writedata;

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
            assign edge_det = ~sync_in & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign edge_det = sync_in ^ prev_q;
        end else begin : g_edge_rise
            assign edge_det = sync_in & ~prev_q;
        end
    endgenerate

    always_comb begin
        out_reg_d  = out_reg_q;
        irq_mask_d = irq_mask_q;
        edge_clr   = '0;
        arm_cnt_d  = arm_cnt_q;
        armed_d    = armed_q;
        prev_d     = sync_in;

        if (wr) begin
            case (address)
                PIO_DATA:   out_reg_d  = wd;
                PIO_MASK:   irq_mask_d = wd;
                PIO_EDGE:   edge_clr   = wd;
                PIO_OUTSET: out_reg_d  = out_reg_q | wd;
                PIO_OUTCLR: out_reg_d  = out_reg_q & ~wd;
                default:    ;
            endcase
        end

        // Clear is applied first so a same-cycle detection wins.
        edge_cap_d = (edge_cap_q & ~edge_clr) | (armed_q ? edge_det : '0);

        if (!armed_q) begin
            arm_cnt_d = arm_cnt_q + CNT_W'(1);
            if (arm_cnt_q == ARM_LAST) begin
                armed_d = 1'b1;
            end
        end

        irq_d = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg_q  <= RESET_VALUE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            prev_q     <= '0;
            arm_cnt_q  <= '0;
            armed_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_reg_q  <= out_reg_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            prev_q     <= prev_d;
            arm_cnt_q  <= arm_cnt_d;
            armed_q    <= armed_d;
            irq_q      <= irq_d;
        end
    end

    // Read mux: zero-extend into a full word so WIDTH=32 needs no special case.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:  readdata[WIDTH-1:0] = sync_in;
            PIO_OUTRB: readdata[WIDTH-1:0] = out_reg_q;
            PIO_MASK:  readdata[WIDTH-1:0] = irq_mask_q;
            PIO_EDGE:  readdata[WIDTH-1:0] = edge_cap_q;
            default:   readdata = '0;
        endcase
    end

    assign out_port = out_reg_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_pio_irq
//  Purpose  : Self-checking bench for pong_pio_irq. An 8-bit rising-edge
//             instance is tracked by a cycle model (input delay line, sticky
//             capture set, register map); a 32-bit any-edge instance gets
//             directed checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_pio_irq;
    import pong_pio_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs8, cs32, write_n;
    logic [31:0] writedata;
    logic [31:0] rd8, rd32;
    logic [7:0]  in8, out8;
    logic [31:0] in32, out32;
    logic        irq8, irq32;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pong_pio_irq #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .in_port(in8), .out_port(out8), .irq(irq8)
    );

    pong_pio_irq #(
        .WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)
    ) u_dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .readdata(rd32),
        .in_port(in32), .out_port(out32), .irq(irq32)
    );

    // ---------------- reference model of the 8-bit instance ----------------
    logic [7:0] m_out, m_mask, m_ecap;
    logic       m_irq;
    logic [7:0] m_hist [SYNC+2];   // m_hist[k] = in_port sampled k edges ago
    int         m_edges;           // clock edges since reset release

    function automatic void model_reset();
        m_out   = 8'hA5;
        m_mask  = 8'h00;
        m_ecap  = 8'h00;
        m_irq   = 1'b0;
        m_edges = 0;
        for (int k = 0; k < SYNC + 2; k++) m_hist[k] = 8'h00;
    endfunction

    function automatic void model_step();
        logic [7:0] wd;
        logic       wr;
        logic       irq_next;
        logic [7:0] det;
        wd = writedata[7:0];
        wr = cs8 & ~write_n;
        irq_next = |(m_ecap & m_mask);
        if (m_edges < SYNC + 2) m_edges++;
        for (int k = SYNC + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = in8;
        // the value reaching the capture logic is SYNC edges old
        det = (m_edges >= SYNC + 2) ? (m_hist[SYNC] & ~m_hist[SYNC+1]) : 8'h00;
        if (wr && address == 3'd3) m_ecap = m_ecap & ~wd;
        m_ecap = m_ecap | det;
        if (wr) begin
            case (address)
                3'd0: m_out  = wd;
                3'd2: m_mask = wd;
                3'd4: m_out  = m_out | wd;
                3'd5: m_out  = m_out & ~wd;
                default: ;
            endcase
        end
        m_irq = irq_next;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_hist[SYNC-1]};
            3'd1:    return {24'h0, m_out};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_ecap};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        #1;
        chk("out_port8", {24'h0, out8}, {24'h0, m_out});
        chk("irq8", {31'h0, irq8}, {31'h0, m_irq});
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v8, output logic [31:0] v32);
        address = a;
        #1;
        v8  = rd8;
        v32 = rd32;
        chk("model_read8", rd8, model_read(a));
    endtask

    task automatic bw(input bit to32, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs8       = !to32;
        cs32      = to32;
        write_n   = 1'b0;
        cyc();
        cs8     = 1'b0;
        cs32    = 1'b0;
        write_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v8, v32;
        reset_n   = 1'b1;
        address   = 3'd0;
        cs8       = 1'b0;
        cs32      = 1'b0;
        write_n   = 1'b1;
        writedata = 32'h0;
        in8       = 8'hFF;     // held high through reset release
        in32      = 32'h0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;

        // reset state
        chk("rst_out_port", {24'h0, out8}, 32'hA5);
        chk("rst_irq", {31'h0, irq8}, 32'h0);
        rd(3'd1, v8, v32); chk("rst_outrb", v8, 32'h0000_00A5);
        rd(3'd2, v8, v32); chk("rst_mask", v8, 32'h0);
        rd(3'd3, v8, v32); chk("rst_edge", v8, 32'h0);

        // arm window: input high at release must not register as an edge
        repeat (6) cyc();
        rd(3'd3, v8, v32); chk("arm_edge", v8, 32'h0);

        // output register, set, clear
        bw(0, 3'd0, 32'hFFFF_FF3C);
        chk("data_wr", {24'h0, out8}, 32'h3C);
        rd(3'd1, v8, v32); chk("outrb_3c", v8, 32'h3C);
        bw(0, 3'd4, 32'h81);
        chk("outset", {24'h0, out8}, 32'hBD);
        bw(0, 3'd5, 32'h0C);
        chk("outclr", {24'h0, out8}, 32'hB1);
        rd(3'd4, v8, v32); chk("rd_outset", v8, 32'h0);
        rd(3'd5, v8, v32); chk("rd_outclr", v8, 32'h0);
        rd(3'd6, v8, v32); chk("rd_a6", v8, 32'h0);
        rd(3'd7, v8, v32); chk("rd_a7", v8, 32'h0);

        // edge latency
        in8 = 8'h00;
        repeat (4) cyc();
        in8 = 8'h04;
        repeat (2) cyc();
        rd(3'd3, v8, v32); chk("edge_early", v8, 32'h0);
        cyc();
        rd(3'd3, v8, v32); chk("edge_lat3", v8, 32'h04);
        rd(3'd0, v8, v32); chk("data_in", v8, 32'h04);

        // irq
        bw(0, 3'd2, 32'h04);
        chk("irq_pre", {31'h0, irq8}, 32'h0);
        cyc();
        chk("irq_set", {31'h0, irq8}, 32'h1);
        bw(0, 3'd3, 32'h04);
        chk("irq_hold", {31'h0, irq8}, 32'h1);
        cyc();
        chk("irq_w1c", {31'h0, irq8}, 32'h0);
        in8 = 8'h00;
        repeat (4) cyc();
        in8 = 8'h04;
        repeat (4) cyc();
        chk("irq_again", {31'h0, irq8}, 32'h1);
        bw(0, 3'd2, 32'h00);
        cyc();
        chk("irq_mask0", {31'h0, irq8}, 32'h0);

        // W1C colliding with a fresh detection
        bw(0, 3'd3, 32'h04);
        in8 = 8'h00;
        repeat (4) cyc();
        in8 = 8'h04;
        repeat (2) cyc();
        bw(0, 3'd3, 32'h04);
        rd(3'd3, v8, v32); chk("set_wins", v8, 32'h04);
        bw(0, 3'd3, 32'h01);
        rd(3'd3, v8, v32); chk("w1c_other", v8, 32'h04);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) in8 = 8'($urandom);
            address   = 3'($urandom_range(0, 7));
            writedata = $urandom;
            cs8       = 1'($urandom_range(0, 1));
            write_n   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            #1;
            chk("rand_rd", rd8, model_read(address));
            cyc();
        end
        cs8     = 1'b0;
        write_n = 1'b1;

        // 32-bit, any-edge instance
        reset_n = 1'b0;
        model_reset();
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (5) cyc();
        bw(1, 3'd0, 32'hDEAD_BEEF);
        chk("w32_out", out32, 32'hDEAD_BEEF);
        rd(3'd1, v8, v32); chk("w32_outrb", v32, 32'hDEAD_BEEF);
        in32 = 32'h8000_0000;
        repeat (3) cyc();
        rd(3'd3, v8, v32); chk("w32_rise", v32, 32'h8000_0000);
        bw(1, 3'd3, 32'h8000_0000);
        rd(3'd3, v8, v32); chk("w32_clr", v32, 32'h0);
        in32 = 32'h0;
        repeat (3) cyc();
        rd(3'd3, v8, v32); chk("w32_fall", v32, 32'h8000_0000);
        bw(1, 3'd2, 32'h8000_0000);
        cyc();
        chk("w32_irq", {31'h0, irq32}, 32'h1);

        // asynchronous reset mid-cycle
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_irq32", {31'h0, irq32}, 32'h0);
        chk("arst_out32", out32, 32'h0);
        chk("arst_out8", {24'h0, out8}, 32'hA5);
        rd(3'd3, v8, v32); chk("arst_edge32", v32, 32'h0);
        rd(3'd2, v8, v32); chk("arst_mask32", v32, 32'h0);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
